// File: rtl/sram_arbiter_pkg.sv
// sram_arbiter_pkg: shared definitions for the unified SRAM port.
//   MAX_CH    - largest supported channel count
//   MAX_ID_W  - channel-id width that covers MAX_CH
//   id_width  - channel-id width for a given channel count (at least 1)
//   tag_t     - read-return tag entry {valid, id}
package sram_arbiter_pkg;

  localparam int MAX_CH   = 8;
  localparam int MAX_ID_W = 3;

  // Width of a channel index; a single channel still gets one bit.
  function automatic int id_width(input int n_ch);
    return (n_ch > 2) ? $clog2(n_ch) : 1;
  endfunction

  // One slot of the read-return tag pipeline. The id is sized for MAX_CH
  // so the type does not depend on the instance parameters.
  typedef struct packed {
    logic                valid;
    logic [MAX_ID_W-1:0] id;
  } tag_t;

endpackage

// File: rtl/sram_arbiter_if.sv
// sram_arbiter_if: request/return bundle between N_CH requesters and the
// shared SRAM port.
//   req    - per-channel request
//   we     - per-channel write (1) / read (0)
//   be     - byte enables, channel k at [k*DATA_W/8 +: DATA_W/8]
//   addr   - byte address, channel k at [k*ADDR_W +: ADDR_W]
//   wdata  - write data, channel k at [k*DATA_W +: DATA_W]
//   gnt    - one-hot (or zero) grant, same cycle as the request
//   rvalid - one-hot read-return strobe
//   rdata  - per-channel read data, meaningful when its rvalid is high
// modport master: requester side; modport slave: arbiter side.
interface sram_arbiter_if #(
  parameter int N_CH   = 2,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);

  logic [N_CH-1:0]          req;
  logic [N_CH-1:0]          we;
  logic [N_CH*DATA_W/8-1:0] be;
  logic [N_CH*ADDR_W-1:0]   addr;
  logic [N_CH*DATA_W-1:0]   wdata;
  logic [N_CH-1:0]          gnt;
  logic [N_CH-1:0]          rvalid;
  logic [N_CH*DATA_W-1:0]   rdata;

  modport master (
    output req, we, be, addr, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, be, addr, wdata,
    output gnt, rvalid, rdata
  );

endinterface

// File: rtl/sram_bank.sv
// sram_bank: single-port word SRAM with byte-enabled writes and a read
// path registered RD_LAT deep.
//   clk    - clock, rising edge
//   reset  - synchronous active-high reset (read pipeline only)
//   rd_en  - read the word at widx this cycle
//   wr_en  - write the enabled bytes of wdata to widx this cycle
//   be     - byte enables for the write
//   widx   - word index
//   wdata  - write data
//   rdata  - read word, RD_LAT cycles after rd_en
module sram_bank #(
  parameter int DATA_W     = 32,
  parameter int DEPTH_LOG2 = 12,
  parameter int RD_LAT     = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rd_en,
  input  logic                  wr_en,
  input  logic [DATA_W/8-1:0]   be,
  input  logic [DEPTH_LOG2-1:0] widx,
  input  logic [DATA_W-1:0]     wdata,
  output logic [DATA_W-1:0]     rdata
);

  logic [DATA_W-1:0] mem_r  [0:(2**DEPTH_LOG2)-1];
  logic [DATA_W-1:0] pipe_r [RD_LAT];

  // Storage array: byte-lane writes, contents deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < DATA_W / 8; b++) begin
        if (be[b]) begin
          mem_r[widx][b*8 +: 8] <= wdata[b*8 +: 8];
        end
      end
    end
  end

  // Read pipeline: stage 0 captures the array, later stages shift every cycle
  // so the word emerges exactly RD_LAT cycles after the read.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < RD_LAT; i++) begin
        pipe_r[i] <= '0;
      end
    end else begin
      if (rd_en) begin
        pipe_r[0] <= mem_r[widx];
      end
      for (int i = 1; i < RD_LAT; i++) begin
        pipe_r[i] <= pipe_r[i-1];
      end
    end
  end

  assign rdata = pipe_r[RD_LAT-1];

endmodule

// File: rtl/sram_arbiter.sv
// sram_arbiter: round-robin arbiter that shares one sram_bank among N_CH
// request channels and returns read data tagged to the requesting channel.
//   clk   - clock, rising edge
//   reset - synchronous active-high reset; also masks all grants
//   bus   - sram_arbiter_if slave modport (req/we/be/addr/wdata in,
//           gnt/rvalid/rdata out)
// Grant is combinational from req and the round-robin pointer; the granted
// access completes in the grant cycle, reads return RD_LAT cycles later.
module sram_arbiter
  import sram_arbiter_pkg::*;
#(
  parameter int N_CH       = 2,
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 32,
  parameter int DEPTH_LOG2 = 12,
  parameter int RD_LAT     = 1
) (
  input  logic          clk,
  input  logic          reset,
  sram_arbiter_if.slave bus
);

  localparam int BE_W = DATA_W / 8;
  localparam int ID_W = id_width(N_CH);

  logic [ID_W-1:0]       ptr_r;
  int                    best_dist_s;
  int                    dist_s;
  logic                  take_s;
  logic [ID_W-1:0]       win_id_s;
  logic                  gnt_any_s;
  logic [N_CH-1:0]       gnt_s;

  logic                  sel_we_s;
  logic [BE_W-1:0]       sel_be_s;
  logic [DEPTH_LOG2-1:0] sel_widx_s;
  logic [DATA_W-1:0]     sel_wdata_s;
  logic                  rd_en_s;
  logic                  wr_en_s;
  logic [DATA_W-1:0]     bank_rdata_s;

  tag_t                  tag_r [RD_LAT];
  tag_t                  tag_out_s;
  logic [N_CH-1:0]       rvalid_s;
  logic [DATA_W-1:0]     hold_r [N_CH];
  logic [N_CH*DATA_W-1:0] rdata_s;

  // Round-robin search: among requesters, the one with the smallest forward
  // distance from the pointer wins (distance 0 = the pointer itself).
  always_comb begin
    best_dist_s = N_CH;
    dist_s      = 0;
    take_s      = 1'b0;
    win_id_s    = '0;
    for (int k = 0; k < N_CH; k++) begin
      dist_s      = (k >= int'(ptr_r)) ? (k - int'(ptr_r)) : (k - int'(ptr_r) + N_CH);
      take_s      = bus.req[k] && (dist_s < best_dist_s);
      best_dist_s = take_s ? dist_s : best_dist_s;
      win_id_s    = take_s ? ID_W'(k) : win_id_s;
    end
  end

  // One-hot grant decode; reset suppresses every grant.
  always_comb begin
    gnt_s     = '0;
    gnt_any_s = !reset && (best_dist_s < N_CH);
    for (int k = 0; k < N_CH; k++) begin
      gnt_s[k] = gnt_any_s && (win_id_s == ID_W'(k));
    end
  end

  assign bus.gnt = gnt_s;

  // AND-OR steering of the granted channel's fields; zero when nobody wins.
  always_comb begin
    sel_we_s    = 1'b0;
    sel_be_s    = '0;
    sel_widx_s  = '0;
    sel_wdata_s = '0;
    for (int k = 0; k < N_CH; k++) begin
      sel_we_s    = sel_we_s    | (gnt_s[k] & bus.we[k]);
      sel_be_s    = sel_be_s    | ({BE_W{gnt_s[k]}} & bus.be[k*BE_W +: BE_W]);
      // Word index is addr[DEPTH_LOG2+1:2]; other address bits alias.
      sel_widx_s  = sel_widx_s  | ({DEPTH_LOG2{gnt_s[k]}} & bus.addr[k*ADDR_W + 2 +: DEPTH_LOG2]);
      sel_wdata_s = sel_wdata_s | ({DATA_W{gnt_s[k]}} & bus.wdata[k*DATA_W +: DATA_W]);
    end
  end

  assign rd_en_s = gnt_any_s & ~sel_we_s;
  assign wr_en_s = gnt_any_s &  sel_we_s;

  sram_bank #(
    .DATA_W     (DATA_W),
    .DEPTH_LOG2 (DEPTH_LOG2),
    .RD_LAT     (RD_LAT)
  ) u_bank (
    .clk   (clk),
    .reset (reset),
    .rd_en (rd_en_s),
    .wr_en (wr_en_s),
    .be    (sel_be_s),
    .widx  (sel_widx_s),
    .wdata (sel_wdata_s),
    .rdata (bank_rdata_s)
  );

  // Round-robin pointer: moves just past the winner, holds when idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_r <= '0;
    end else if (gnt_any_s) begin
      ptr_r <= (win_id_s == ID_W'(N_CH - 1)) ? '0 : win_id_s + ID_W'(1);
    end
  end

  // Tag pipeline runs in lock-step with the bank read pipeline; reset
  // empties it so in-flight reads never return.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < RD_LAT; i++) begin
        tag_r[i] <= '0;
      end
    end else begin
      tag_r[0].valid <= rd_en_s;
      tag_r[0].id    <= MAX_ID_W'(win_id_s);
      for (int i = 1; i < RD_LAT; i++) begin
        tag_r[i] <= tag_r[i-1];
      end
    end
  end

  assign tag_out_s = tag_r[RD_LAT-1];

  // Decode the exiting tag into the one-hot return strobe.
  always_comb begin
    rvalid_s = '0;
    for (int k = 0; k < N_CH; k++) begin
      rvalid_s[k] = tag_out_s.valid && (tag_out_s.id == MAX_ID_W'(k));
    end
  end

  // Per-channel copy of the last returned word, so idle channels hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < N_CH; k++) begin
        hold_r[k] <= '0;
      end
    end else begin
      for (int k = 0; k < N_CH; k++) begin
        if (rvalid_s[k]) begin
          hold_r[k] <= bank_rdata_s;
        end
      end
    end
  end

  // The returning channel sees the bank word directly in its rvalid cycle.
  always_comb begin
    rdata_s = '0;
    for (int k = 0; k < N_CH; k++) begin
      rdata_s[k*DATA_W +: DATA_W] = rvalid_s[k] ? bank_rdata_s : hold_r[k];
    end
  end

  assign bus.rvalid = rvalid_s;
  assign bus.rdata  = rdata_s;

endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: self-checking bench for sram_arbiter with three channels
// and a three-cycle read latency. A behavioural model (word store keyed by
// aliased index, pointer arithmetic, queue of due returns) predicts every
// grant, strobe and data word; a vector table and short directed sequences
// add constant expectations for the listed corner cases.
module tb_sram_arbiter;

  localparam int N   = 3;
  localparam int DW  = 32;
  localparam int AW  = 32;
  localparam int DL  = 12;
  localparam int LAT = 3;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  always #5 clk = ~clk;

  sram_arbiter_if #(.N_CH(N), .DATA_W(DW), .ADDR_W(AW)) bus ();

  sram_arbiter #(
    .N_CH       (N),
    .DATA_W     (DW),
    .ADDR_W     (AW),
    .DEPTH_LOG2 (DL),
    .RD_LAT     (LAT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  bit model_live = 1'b0;
  int ptr_m  = 0;

  logic [31:0] ref_mem [int];

  typedef struct {
    int          due;
    int          ch;
    logic [31:0] data;
  } ret_t;

  ret_t        pend_q [$];
  logic [31:0] exp_rdata [N];

  typedef struct {
    int          ch;
    bit          we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t tbl [9];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic int widx_of(input logic [31:0] a);
    return int'((a >> 2) & ((32'd1 << DL) - 32'd1));
  endfunction

  function automatic int model_pick(input logic [N-1:0] r);
    for (int i = 0; i < N; i++) begin
      int ch;
      ch = (ptr_m + i) % N;
      if (r[ch]) return ch;
    end
    return -1;
  endfunction

  // Compare rvalid/rdata of the current cycle with the due returns.
  task automatic check_returns();
    logic [N-1:0] exp_v;
    exp_v = '0;
    if (model_live) begin
      for (int i = pend_q.size() - 1; i >= 0; i--) begin
        if (pend_q[i].due == cyc) begin
          exp_v[pend_q[i].ch]     = 1'b1;
          exp_rdata[pend_q[i].ch] = pend_q[i].data;
          pend_q.delete(i);
        end
      end
      chk("rvalid", bus.rvalid, exp_v);
      for (int k = 0; k < N; k++) begin
        chk($sformatf("rdata%0d", k), bus.rdata[k*DW +: DW], exp_rdata[k]);
      end
    end
  endtask

  // One clock cycle: check returns, drive inputs, check grant, advance model.
  task automatic step(input bit rst, input logic [N-1:0] r, input logic [N-1:0] w,
                      input logic [4*N-1:0] b, input logic [AW*N-1:0] a,
                      input logic [DW*N-1:0] d, output logic [N-1:0] g_obs,
                      output int c);
    logic [N-1:0] exp_g;
    logic [31:0]  word;
    int           wi;
    check_returns();
    reset     = rst;
    bus.req   = r;
    bus.we    = w;
    bus.be    = b;
    bus.addr  = a;
    bus.wdata = d;
    #1;
    c     = rst ? -1 : model_pick(r);
    exp_g = '0;
    if (c >= 0) exp_g[c] = 1'b1;
    g_obs = bus.gnt;
    chk("gnt", bus.gnt, exp_g);
    if (rst) begin
      model_live = 1'b1;
      ptr_m      = 0;
      pend_q.delete();
      for (int k = 0; k < N; k++) exp_rdata[k] = 32'h0;
    end else if (c >= 0) begin
      ptr_m = (c + 1) % N;
      wi    = widx_of(a[c*AW +: AW]);
      word  = ref_mem.exists(wi) ? ref_mem[wi] : 32'bx;
      if (w[c]) begin
        for (int j = 0; j < 4; j++) begin
          if (b[c*4 + j]) word[j*8 +: 8] = d[c*DW + j*8 +: 8];
        end
        ref_mem[wi] = word;
      end else begin
        pend_q.push_back('{cyc + LAT, c, word});
      end
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic op(input int ch, input bit w, input logic [3:0] b, input logic [31:0] a,
                    input logic [31:0] d, output logic [N-1:0] g_obs);
    logic [N-1:0]    r, wv;
    logic [4*N-1:0]  bv;
    logic [AW*N-1:0] av;
    logic [DW*N-1:0] dv;
    int              c;
    r = '0; wv = '0; bv = '0; av = '0; dv = '0;
    r[ch]            = 1'b1;
    wv[ch]           = w;
    bv[ch*4 +: 4]    = b;
    av[ch*AW +: AW]  = a;
    dv[ch*DW +: DW]  = d;
    step(1'b0, r, wv, bv, av, dv, g_obs, c);
  endtask

  task automatic idle(input int n);
    logic [N-1:0] g;
    int           c;
    for (int i = 0; i < n; i++) step(1'b0, '0, '0, '0, '0, '0, g, c);
  endtask

  task automatic do_reset();
    logic [N-1:0] g;
    int           c;
    step(1'b1, '0, '0, '0, '0, '0, g, c);
  endtask

  // Reads on several channels with fixed addresses (ch0 0x10, ch1 0x20, ch2 0x10).
  task automatic multi_read(input logic [N-1:0] r, output logic [N-1:0] g_obs);
    logic [AW*N-1:0] av;
    int              c;
    av = {32'h10, 32'h20, 32'h10};
    step(1'b0, r, '0, '0, av, '0, g_obs, c);
  endtask

  initial begin
    logic [N-1:0] g;
    logic         pv [N];
    logic         pwe [N];
    logic [3:0]   pbe [N];
    logic [31:0]  pad [N];
    logic [31:0]  pwd [N];

    tbl[0] = '{0, 1'b1, 4'hF, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0};
    tbl[1] = '{0, 1'b0, 4'h0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF};
    tbl[2] = '{1, 1'b1, 4'hF, 32'h0000_0020, 32'h1122_3344, 32'h0};
    tbl[3] = '{1, 1'b1, 4'h2, 32'h0000_0020, 32'hAABB_CCDD, 32'h0};
    tbl[4] = '{1, 1'b0, 4'h0, 32'h0000_0020, 32'h0,         32'h1122_CC44};
    tbl[5] = '{2, 1'b1, 4'hF, 32'h0000_4008, 32'h5A5A_5A5A, 32'h0};
    tbl[6] = '{0, 1'b0, 4'h0, 32'h0000_0008, 32'h0,         32'h5A5A_5A5A};
    tbl[7] = '{2, 1'b1, 4'h0, 32'h0000_0010, 32'h0,         32'h0};
    tbl[8] = '{2, 1'b0, 4'h0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF};

    bus.req = '0; bus.we = '0; bus.be = '0; bus.addr = '0; bus.wdata = '0;
    @(posedge clk);
    #1;
    do_reset();
    do_reset();

    // Vector table: single-channel accesses with constant expectations.
    for (int i = 0; i < 9; i++) begin
      logic [N-1:0] eg;
      eg = '0;
      eg[tbl[i].ch] = 1'b1;
      op(tbl[i].ch, tbl[i].we, tbl[i].be, tbl[i].addr, tbl[i].wdata, g);
      chk($sformatf("tbl%0d_gnt", i), g, eg);
      if (!tbl[i].we) begin
        idle(LAT - 1);
        chk($sformatf("tbl%0d_rvalid", i), bus.rvalid, eg);
        chk($sformatf("tbl%0d_rdata", i), bus.rdata[tbl[i].ch*DW +: DW], tbl[i].exp_rd);
      end
    end
    idle(LAT + 1);

    // Channels 0 and 1 reading continuously alternate, starting at 0.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      multi_read(3'b011, g);
      chk($sformatf("alt%0d_gnt", i), g, (i % 2 == 0) ? 3'b001 : 3'b010);
    end
    idle(LAT + 1);

    // Reset one cycle after a read grant discards the read.
    do_reset();
    multi_read(3'b010, g);
    chk("rstrd_gnt", g, 3'b010);
    do_reset();
    for (int i = 0; i < LAT + 1; i++) begin
      chk("rstrd_rvalid", bus.rvalid, 3'b000);
      chk("rstrd_rdata", bus.rdata, 96'h0);
      idle(1);
    end
    multi_read(3'b111, g);
    chk("rstrd_next_gnt", g, 3'b001);
    idle(LAT + 1);

    // Lone channel 2 is granted every cycle; the pointer wraps to 0.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      multi_read(3'b100, g);
      chk($sformatf("ch2_%0d_gnt", i), g, 3'b100);
    end
    multi_read(3'b111, g);
    chk("ch2_wrap_gnt", g, 3'b001);
    idle(LAT + 1);

    // Give every word used by the random phase a known value.
    for (int i = 0; i < 16; i++) op(0, 1'b1, 4'hF, 32'(i * 4), $urandom, g);

    // Random traffic: requests held until granted, occasional drops/resets.
    for (int k = 0; k < N; k++) pv[k] = 1'b0;
    for (int t = 0; t < 600; t++) begin
      logic [N-1:0]    r, wv;
      logic [4*N-1:0]  bv;
      logic [AW*N-1:0] av;
      logic [DW*N-1:0] dv;
      int              c;
      r = '0; wv = '0; bv = '0; av = '0; dv = '0;
      for (int k = 0; k < N; k++) begin
        if (pv[k] && $urandom_range(0, 99) < 4) begin
          pv[k] = 1'b0;
        end else if (!pv[k] && $urandom_range(0, 99) < 55) begin
          pv[k]        = 1'b1;
          pwe[k]       = 1'($urandom_range(0, 1));
          pbe[k]       = 4'($urandom);
          pad[k]       = $urandom;
          pad[k][13:2] = 12'($urandom_range(0, 15));
          pwd[k]       = $urandom;
        end
        r[k]            = pv[k];
        wv[k]           = pwe[k];
        bv[k*4 +: 4]    = pbe[k];
        av[k*AW +: AW]  = pad[k];
        dv[k*DW +: DW]  = pwd[k];
      end
      step(($urandom_range(0, 149) == 0), r, wv, bv, av, dv, g, c);
      if (c >= 0) pv[c] = 1'b0;
    end
    idle(LAT + 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
